// File: rtl/mem_bank_pipelined.sv
// Parametrised single-port memory bank: byte-enable writes, RD_LAT-cycle read pipeline,
// post-reset zero-fill, and out-of-range request flagging.
module mem_bank_pipelined #(
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 16,
   parameter int ADDR_W  = 4,
   parameter int RD_LAT  = 1,
   parameter int INIT_EN = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_EN,
   input  logic                  i_WE,
   input  logic [DATA_W/8-1:0]   i_byte_en,
   input  logic [ADDR_W-1:0]     i_address,
   input  logic [DATA_W-1:0]     i_data_in,
   output logic [DATA_W-1:0]     o_data_out,
   output logic                  o_valid,
   output logic                  o_ready,
   output logic                  o_addr_err,
   output logic                  o_dbg_state
);

   localparam int NB     = DATA_W / 8;
   localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PIPE_N = (RD_LAT > 1) ? RD_LAT - 1 : 1;
   localparam logic [ADDR_W:0]  DEPTH_A  = (ADDR_W + 1)'(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   typedef enum logic {S_INIT = 1'b0, S_READY = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  cnt_q, cnt_d;
   logic              fill_we;
   logic              ready_q;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [IDX_W-1:0]  idx;
   logic              in_range, req, rd_req, wr_req, wr_oor;
   logic [DATA_W-1:0] rd_data;
   logic              fin_v, fin_e;
   logic [DATA_W-1:0] fin_d;

   // Handshake: i_EN marks a one-cycle request; it is taken only while o_ready=1 and
   // is silently dropped otherwise. o_valid/o_addr_err are single-cycle pulses, no backpressure.
   assign idx      = i_address[IDX_W-1:0];
   assign in_range = ({1'b0, i_address} < DEPTH_A);
   assign req      = i_EN & ready_q;
   assign rd_req   = req & ~i_WE;
   assign wr_req   = req & i_WE & in_range;
   assign wr_oor   = req & i_WE & ~in_range;
   assign rd_data  = in_range ? mem[idx] : '0;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= (INIT_EN != 0) ? S_INIT : S_READY;
         cnt_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= (state_d == S_READY);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fill_we = 1'b0;
      case (state_q)
         S_INIT: begin
            fill_we = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST_IDX) state_d = S_READY;
         end
         default: ;
      endcase
   end

   // Fill and user writes never overlap: requests are gated off until the fill finishes.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         if (fill_we) begin
            mem[cnt_q] <= '0;
         end else if (wr_req) begin
            for (int b = 0; b < NB; b++) begin
               if (i_byte_en[b]) mem[idx][8*b +: 8] <= i_data_in[8*b +: 8];
            end
         end
      end
   end

   generate
      if (RD_LAT == 1) begin : g_lat1
         assign fin_v = rd_req;
         assign fin_e = rd_req & ~in_range;
         assign fin_d = rd_data;
      end else begin : g_pipe
         logic [PIPE_N-1:0] v_q, e_q;
         logic [DATA_W-1:0] d_q [PIPE_N];

         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               v_q <= '0;
               e_q <= '0;
            end else begin
               v_q[0] <= rd_req;
               e_q[0] <= rd_req & ~in_range;
               for (int s = 1; s < PIPE_N; s++) begin
                  v_q[s] <= v_q[s-1];
                  e_q[s] <= e_q[s-1];
               end
            end
            d_q[0] <= rd_data;
            for (int s = 1; s < PIPE_N; s++) d_q[s] <= d_q[s-1];
         end

         assign fin_v = v_q[PIPE_N-1];
         assign fin_e = e_q[PIPE_N-1];
         assign fin_d = d_q[PIPE_N-1];
      end
   endgenerate

   // Output stage: the last pipeline slot lands here, so total read latency is RD_LAT.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_valid    <= 1'b0;
         o_addr_err <= 1'b0;
         o_data_out <= '0;
      end else begin
         o_valid    <= fin_v;
         o_addr_err <= (fin_v & fin_e) | wr_oor;
         if (fin_v) o_data_out <= fin_d;
      end
   end

   assign o_ready     = ready_q;
   assign o_dbg_state = (state_q == S_READY);

endmodule

// File: tb/tb_mem_bank_pipelined.sv
// Bench for mem_bank_pipelined: two instances (16 words/latency 1, 12 words/latency 3)
// share one stimulus stream; a cycle model plus expected-data queues check every output.
module tb_mem_bank_pipelined;

   logic        clk;
   logic        rst, en, we;
   logic [3:0]  be;
   logic [3:0]  addr;
   logic [31:0] din;

   logic [31:0] dout  [2];
   logic        valid [2];
   logic        ready [2];
   logic        aerr  [2];
   logic        dbg   [2];

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   logic [31:0] m_mem [2][16];
   logic        m_ready [2];
   int          m_cnt [2];
   logic        m_v [2], m_e [2];
   logic [31:0] m_d [2];
   logic        sv [2][8], se [2][8];
   logic [31:0] sd [2][8];
   int          cyc;
   logic [31:0] exp_q_a[$];
   logic [31:0] exp_q_b[$];

   int rdy_a, rdy_b;

   mem_bank_pipelined #(.DATA_W(32), .DEPTH(16), .ADDR_W(4), .RD_LAT(1), .INIT_EN(1)) u_dut_a (
      .i_clk(clk), .i_rst(rst), .i_EN(en), .i_WE(we), .i_byte_en(be), .i_address(addr),
      .i_data_in(din), .o_data_out(dout[0]), .o_valid(valid[0]), .o_ready(ready[0]),
      .o_addr_err(aerr[0]), .o_dbg_state(dbg[0]));

   mem_bank_pipelined #(.DATA_W(32), .DEPTH(12), .ADDR_W(4), .RD_LAT(3), .INIT_EN(1)) u_dut_b (
      .i_clk(clk), .i_rst(rst), .i_EN(en), .i_WE(we), .i_byte_en(be), .i_address(addr),
      .i_data_in(din), .o_data_out(dout[1]), .o_valid(valid[1]), .o_ready(ready[1]),
      .o_addr_err(aerr[1]), .o_dbg_state(dbg[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int dep_of(input int k);
      return (k == 0) ? 16 : 12;
   endfunction

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      logic acc, oor;
      int   slot;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_ready[k] = 1'b0;
            m_cnt[k]   = 0;
            m_v[k]     = 1'b0;
            m_e[k]     = 1'b0;
            m_d[k]     = '0;
            for (int s = 0; s < 8; s++) sv[k][s] = 1'b0;
            if (k == 0) exp_q_a.delete(); else exp_q_b.delete();
         end else begin
            acc    = m_ready[k] && en;
            oor    = (int'(addr) >= dep_of(k));
            m_e[k] = 1'b0;
            if (acc && we) begin
               if (oor) m_e[k] = 1'b1;
               else for (int b = 0; b < 4; b++)
                  if (be[b]) m_mem[k][addr][8*b +: 8] = din[8*b +: 8];
            end
            if (acc && !we) begin
               slot = (cyc + lat_of(k) - 1) % 8;
               sv[k][slot] = 1'b1;
               se[k][slot] = oor;
               sd[k][slot] = oor ? 32'h0 : m_mem[k][addr];
               if (k == 0) exp_q_a.push_back(sd[k][slot]); else exp_q_b.push_back(sd[k][slot]);
            end
            m_v[k] = sv[k][cyc % 8];
            sv[k][cyc % 8] = 1'b0;
            if (m_v[k]) begin
               m_d[k] = sd[k][cyc % 8];
               if (se[k][cyc % 8]) m_e[k] = 1'b1;
            end
            if (!m_ready[k]) begin
               m_mem[k][m_cnt[k]] = '0;
               if (m_cnt[k] == dep_of(k) - 1) m_ready[k] = 1'b1;
               m_cnt[k]++;
            end
         end
      end
      cyc++;
   endtask

   task automatic monitor();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("ready%0d", k), 32'(ready[k]), 32'(m_ready[k]));
         chk($sformatf("state%0d", k), 32'(dbg[k]),   32'(m_ready[k]));
         chk($sformatf("valid%0d", k), 32'(valid[k]), 32'(m_v[k]));
         chk($sformatf("aerr%0d", k),  32'(aerr[k]),  32'(m_e[k]));
         chk($sformatf("dout%0d", k),  dout[k],       m_d[k]);
         if (valid[k] === 1'b1) begin
            if (k == 0) begin
               chk("sb_nonempty0", 32'(exp_q_a.size() > 0), 32'd1);
               if (exp_q_a.size() > 0) chk("sb_data0", dout[0], exp_q_a.pop_front());
            end else begin
               chk("sb_nonempty1", 32'(exp_q_b.size() > 0), 32'd1);
               if (exp_q_b.size() > 0) chk("sb_data1", dout[1], exp_q_b.pop_front());
            end
         end
      end
   endtask

   // inputs are set at a negedge, consumed at the posedge, outputs checked at the next negedge
   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      monitor();
   endtask

   task automatic wait_ready(input logic inject);
      rdy_a = 0;
      rdy_b = 0;
      for (int i = 1; i <= 40; i++) begin
         if (inject && i == 3) begin
            en = 1'b1; we = 1'b1; be = 4'hF; addr = 4'd5; din = 32'hFFFF_FFFF;
         end else begin
            en = 1'b0;
         end
         step();
         if (ready[0] === 1'b1 && rdy_a == 0) rdy_a = i;
         if (ready[1] === 1'b1 && rdy_b == 0) rdy_b = i;
         if (rdy_a != 0 && rdy_b != 0) break;
      end
      chk("ready_lat_a", rdy_a, 32'd16);
      chk("ready_lat_b", rdy_b, 32'd12);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; we = 1'b0; be = '0; addr = '0; din = '0; cyc = 0;
      @(negedge clk);
      step();
      step();
      chk("rst_dout_a", dout[0], 32'h0);
      chk("rst_ready_b", 32'(ready[1]), 32'd0);
      rst = 1'b0;
      wait_ready(1'b1);

      // sweep every address: zeros everywhere, 12..15 out of range on instance b
      for (int a = 0; a < 16; a++) begin
         en = 1'b1; we = 1'b0; addr = 4'(a);
         step();
      end
      en = 1'b0;
      for (int i = 0; i < 4; i++) step();

      // byte-enable merge, read immediately after the second write
      en = 1'b1; we = 1'b1; be = 4'hF; addr = 4'd3; din = 32'hDEAD_BEEF;
      step();
      be = 4'b0101; din = 32'h1122_3344;
      step();
      we = 1'b0;
      step();
      chk("be_merge_valid_a", 32'(valid[0]), 32'd1);
      chk("be_merge_a", dout[0], 32'hDE22_BE44);
      en = 1'b0;
      step();
      step();
      chk("be_merge_valid_b", 32'(valid[1]), 32'd1);
      chk("be_merge_b", dout[1], 32'hDE22_BE44);

      // back-to-back reads on the latency-3 bank
      for (int a = 1; a <= 3; a++) begin
         en = 1'b1; we = 1'b1; be = 4'hF; addr = 4'(a); din = 32'hA0 + 32'(a);
         step();
      end
      for (int a = 1; a <= 3; a++) begin
         we = 1'b0; addr = 4'(a);
         step();
      end
      en = 1'b0;
      chk("b2b_v1_b", 32'(valid[1]), 32'd1);
      chk("b2b_d1_b", dout[1], 32'hA1);
      step();
      chk("b2b_d2_b", dout[1], 32'hA2);
      step();
      chk("b2b_d3_b", dout[1], 32'hA3);
      step();
      chk("b2b_idle_valid_b", 32'(valid[1]), 32'd0);
      chk("b2b_hold_b", dout[1], 32'hA3);

      // address 13: in range for a, out of range for b
      en = 1'b1; we = 1'b1; be = 4'hF; addr = 4'd13; din = 32'h55;
      step();
      chk("oor_wr_err_b", 32'(aerr[1]), 32'd1);
      chk("oor_wr_noerr_a", 32'(aerr[0]), 32'd0);
      we = 1'b0;
      step();
      chk("inr_rd_a", dout[0], 32'h55);
      chk("oor_rd_early_b", 32'(aerr[1]), 32'd0);
      en = 1'b0;
      step();
      step();
      chk("oor_rd_valid_b", 32'(valid[1]), 32'd1);
      chk("oor_rd_data_b", dout[1], 32'h0);
      chk("oor_rd_err_b", 32'(aerr[1]), 32'd1);

      // random traffic
      for (int i = 0; i < 300; i++) begin
         en   = ($urandom_range(0, 3) != 0);
         we   = 1'($urandom_range(0, 1));
         be   = 4'($urandom_range(0, 15));
         addr = 4'($urandom_range(0, 15));
         din  = $urandom;
         step();
      end
      en = 1'b0;
      for (int i = 0; i < 6; i++) step();

      // reset with two reads in flight on instance b
      en = 1'b1; we = 1'b0; addr = 4'd1;
      step();
      addr = 4'd2;
      step();
      en = 1'b0; rst = 1'b1;
      step();
      chk("rst_fl_valid_b", 32'(valid[1]), 32'd0);
      chk("rst_fl_dout_b", dout[1], 32'h0);
      chk("rst_fl_ready_a", 32'(ready[0]), 32'd0);
      step();
      rst = 1'b0;
      wait_ready(1'b0);
      en = 1'b1; we = 1'b0; addr = 4'd1;
      step();
      chk("refill_rd_a", dout[0], 32'h0);
      en = 1'b0;
      for (int i = 0; i < 4; i++) step();

      chk("sb_left_a", 32'(exp_q_a.size()), 32'd0);
      chk("sb_left_b", 32'(exp_q_b.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
